// File: rtl/gem_cluster_pkg.sv
// Shared types and defaults for the GEM cluster packer encoder path.
// Used by the latch scheduler and the encoder output mux.
package gem_cluster_pkg;

    localparam int NUM_ENC         = 2;
    localparam int LATCH_DLY_DEF   = 3;
    localparam int MUX_DLY_DEF     = 7;
    localparam int ENC_TIMEOUT_DEF = 15;
    localparam int CNT_W_DEF       = 16;

    typedef enum logic {
        SLOT_IDLE = 1'b0,
        SLOT_BUSY = 1'b1
    } slot_state_t;

    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/encoder_slot_fsm.sv
// Busy-window tracker for one priority encoder: start, drop,
// done and timeout handling with registered strobes.
module encoder_slot_fsm
    import gem_cluster_pkg::*;
#(
    parameter int ENC_TIMEOUT = ENC_TIMEOUT_DEF
) (
    input  logic clock4x,
    input  logic reset_n,
    input  logic req,
    input  logic done,
    output logic start,
    output logic busy,
    output logic drop,
    output logic tmo
);

    localparam int AW = $clog2(ENC_TIMEOUT);
    localparam logic [AW-1:0] AGE_LAST = AW'(ENC_TIMEOUT - 1);

    slot_state_t   state;
    logic [AW-1:0] age;
    logic          expired;
    logic          freed;

    assign busy    = (state == SLOT_BUSY);
    assign expired = (age == AGE_LAST) && !done;
    assign freed   = done || (age == AGE_LAST);

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            state <= SLOT_IDLE;
            age   <= '0;
            start <= 1'b0;
            drop  <= 1'b0;
            tmo   <= 1'b0;
        end else begin
            start <= 1'b0;
            drop  <= 1'b0;
            tmo   <= 1'b0;
            unique case (state)
                SLOT_IDLE: begin
                    if (req) begin
                        state <= SLOT_BUSY;
                        start <= 1'b1;
                        age   <= '0;
                    end
                end
                SLOT_BUSY: begin
                    // A slot freed this cycle serves a coincident request.
                    if (req && freed) begin
                        start <= 1'b1;
                        age   <= '0;
                        tmo   <= expired;
                    end else if (freed) begin
                        state <= SLOT_IDLE;
                        tmo   <= expired;
                    end else if (req) begin
                        drop <= 1'b1;
                        age  <= age + 1'b1;
                    end else begin
                        age <= age + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/encoder_latch_sched.sv
// Latch divider and dispatcher for the two first16of1536 encoders,
// with drop/timeout accounting and the delayed merge mux select.
module encoder_latch_sched
    import gem_cluster_pkg::*;
#(
    parameter int LATCH_DLY   = LATCH_DLY_DEF,
    parameter int MUX_DLY     = MUX_DLY_DEF,
    parameter int ENC_TIMEOUT = ENC_TIMEOUT_DEF,
    parameter int CNT_W       = CNT_W_DEF
) (
    input  logic               clock4x,
    input  logic               reset_n,
    input  logic               enable,
    input  logic               latch_pulse,
    input  logic [1:0]         enc_done,
    output logic [1:0]         enc_start,
    output logic [1:0]         enc_busy,
    output logic               mux_sel,
    output logic               mux_valid,
    output logic [CNT_W-1:0]   drop_cnt,
    output logic [CNT_W-1:0]   tmo_cnt,
    output logic               err_tmo
);

    logic                 phase;
    logic                 accept;
    logic [LATCH_DLY-1:0] dly;
    logic [NUM_ENC-1:0]   req;
    logic [NUM_ENC-1:0]   drop_p;
    logic [NUM_ENC-1:0]   tmo_p;
    logic [CNT_W:0]       drop_sum;
    logic [CNT_W:0]       tmo_sum;
    logic                 tog;
    logic                 tog_next;
    logic [MUX_DLY-1:0]   sel_sr;
    logic [MUX_DLY-1:0]   val_sr;

    assign accept = latch_pulse && enable && !phase;
    assign req    = {dly[LATCH_DLY-1], accept};

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            phase <= 1'b0;
        end else if (!enable) begin
            phase <= 1'b0;
        end else if (latch_pulse) begin
            phase <= !phase;
        end
    end

    // Encoder-1 requests are committed once launched; enable does not gate them.
    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            dly <= '0;
        end else begin
            for (int i = LATCH_DLY - 1; i > 0; i--) begin
                dly[i] <= dly[i-1];
            end
            dly[0] <= accept;
        end
    end

    for (genvar g = 0; g < NUM_ENC; g++) begin : g_slot
        encoder_slot_fsm #(
            .ENC_TIMEOUT(ENC_TIMEOUT)
        ) u_slot (
            .clock4x(clock4x),
            .reset_n(reset_n),
            .req    (req[g]),
            .done   (enc_done[g]),
            .start  (enc_start[g]),
            .busy   (enc_busy[g]),
            .drop   (drop_p[g]),
            .tmo    (tmo_p[g])
        );
    end

    always_comb begin
        drop_sum = {1'b0, drop_cnt} + {{(CNT_W-1){1'b0}}, pop2(drop_p)};
        tmo_sum  = {1'b0, tmo_cnt} + {{(CNT_W-1){1'b0}}, pop2(tmo_p)};
    end

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt <= '0;
            tmo_cnt  <= '0;
            err_tmo  <= 1'b0;
        end else begin
            drop_cnt <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
            tmo_cnt  <= tmo_sum[CNT_W] ? '1 : tmo_sum[CNT_W-1:0];
            err_tmo  <= err_tmo || (|tmo_p);
        end
    end

    // Encoder 0 wins when both report in the same cycle.
    always_comb begin
        tog_next = tog;
        if (enc_done[0]) begin
            tog_next = 1'b1;
        end else if (enc_done[1]) begin
            tog_next = 1'b0;
        end
    end

    always_ff @(posedge clock4x or negedge reset_n) begin
        if (!reset_n) begin
            tog    <= 1'b0;
            sel_sr <= '0;
            val_sr <= '0;
        end else begin
            tog <= tog_next;
            for (int i = MUX_DLY - 1; i > 0; i--) begin
                sel_sr[i] <= sel_sr[i-1];
                val_sr[i] <= val_sr[i-1];
            end
            sel_sr[0] <= tog_next;
            val_sr[0] <= |enc_done;
        end
    end

    assign mux_sel   = sel_sr[MUX_DLY-1];
    assign mux_valid = val_sr[MUX_DLY-1];

endmodule
